// File: rtl/alu.sv
// Registered unsigned adder slice: captures a + b into c on a valid clock edge
// and holds c otherwise. c is cleared asynchronously while reset is low.
module alu #(
    parameter int DATA_W = 4,
    parameter int OUT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              valid,
    output logic [OUT_W-1:0]  c
);

    // The result must hold the carry-out, so it needs at least one bit beyond the operands
    generate
        if (OUT_W < DATA_W + 1) begin : g_width_check
            $error("alu: OUT_W must be >= DATA_W+1");
        end
    endgenerate

    logic [OUT_W-1:0] sum_s;
    logic [OUT_W-1:0] c_d;
    logic [OUT_W-1:0] c_q;

    // Zero-extended sum; operands are widened first so the carry lands in bit DATA_W
    always_comb begin
        sum_s = {OUT_W{1'b0}};
        sum_s = OUT_W'(a) + OUT_W'(b);
    end

    // Next-state select; operands are ignored while valid is low, so X on them cannot reach c
    always_comb begin
        c_d = c_q;
        if (valid) begin
            c_d = sum_s;
        end else begin
            c_d = c_q;
        end
    end

    // Result register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q <= {OUT_W{1'b0}};
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, async-reset sequences
// and a random run against a one-cycle-latency scoreboard.
module tb_alu;

    localparam int DATA_W = 4;
    localparam int OUT_W  = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] a = 4'd0;
    logic [DATA_W-1:0] b = 4'd0;
    logic              valid = 1'b0;
    logic [OUT_W-1:0]  c;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OUT_W-1:0]  exp_c;
    } vec_t;

    vec_t vecs[9];

    alu #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .valid (valid),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: c=%0d (%b) expected %0d", name, got, got, exp);
        end
    endtask

    initial begin
        logic [OUT_W-1:0] model_c;
        logic             rv;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;

        vecs[0] = '{1'b1, 4'd4,  4'd9,  7'd13};
        vecs[1] = '{1'b0, 4'd1,  4'd1,  7'd13};
        vecs[2] = '{1'b1, 4'd15, 4'd15, 7'd30};
        vecs[3] = '{1'b1, 4'd0,  4'd0,  7'd0};
        vecs[4] = '{1'b1, 4'd1,  4'd2,  7'd3};
        vecs[5] = '{1'b1, 4'd7,  4'd8,  7'd15};
        vecs[6] = '{1'b1, 4'd15, 4'd1,  7'd16};
        vecs[7] = '{1'b0, 4'bxxxx, 4'bxxxx, 7'd16};
        vecs[8] = '{1'b0, 4'd3,  4'bxxxx, 7'd16};

        // Reset held with valid operands present: c must stay 0 across edges
        #1;
        reset = 1'b0;
        valid = 1'b1;
        a = 4'd5;
        b = 4'd3;
        #1;
        check("reset_async_clear", c, 7'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", c, 7'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("reset_release_first_capture", c, 7'd8);

        for (int i = 0; i < 9; i++) begin
            valid = vecs[i].v;
            a = vecs[i].a;
            b = vecs[i].b;
            @(negedge clk);
            check($sformatf("vec%0d", i), c, vecs[i].exp_c);
        end

        // Async reset between edges, with a valid request pending
        valid = 1'b1;
        a = 4'd9;
        b = 4'd9;
        #2;
        reset = 1'b0;
        #1;
        check("midstream_reset_before_edge", c, 7'd0);
        @(negedge clk);
        check("midstream_reset_discard", c, 7'd0);
        valid = 1'b0;
        a = 4'd6;
        b = 4'd6;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("release_idle_hold", c, 7'd0);
        end

        model_c = 7'd0;
        for (int i = 0; i < 200; i++) begin
            rv = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            valid = rv;
            a = ra;
            b = rb;
            @(negedge clk);
            if (rv) begin
                model_c = {3'b000, ra} + {3'b000, rb};
            end
            check("random", c, model_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
